// File: rtl/encoder_fixed_point_pkg.sv
// Shared fixed-point helpers for the dense encoder layer: default word format,
// saturation and the Q-format multiply used by every neuron.
package encoder_fixed_point_pkg;

   localparam int BITSIZE_DEF = 32;
   localparam int FRAC_DEF    = 16;
   // Helpers work on fixed wide containers so one definition serves any BITSIZE <= MAXW.
   localparam int MAXW        = 64;
   localparam int WIDEW       = 2 * MAXW;

   typedef logic signed [MAXW-1:0]  word_t;
   typedef logic signed [WIDEW-1:0] wide_t;

   // Clamp v to the signed range of a bits-wide word; the result is still wide.
   function automatic wide_t sat(input wide_t v, input int bits);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (bits - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

   // Full-precision product, floor-shifted back to Q format, then clamped.
   function automatic wide_t fxmul(input word_t a, input word_t c, input int bits, input int frac);
      wide_t prod;
      prod = wide_t'(a) * wide_t'(c);
      return sat(prod >>> frac, bits);
   endfunction

endpackage

// File: rtl/encoder_neuron.sv
// One output neuron: bias plus saturated products, summed at full width,
// saturated once at the end. Purely combinational.
module encoder_neuron
   import encoder_fixed_point_pkg::*;
#(
   parameter int N_input = 9,
   parameter int BITSIZE = BITSIZE_DEF,
   parameter int FRAC    = FRAC_DEF
) (
   input  logic [N_input*BITSIZE-1:0] x,
   input  logic [N_input*BITSIZE-1:0] wcol,
   input  logic [BITSIZE-1:0]         bias,
   output logic [BITSIZE-1:0]         y
);

   // Headroom for N_input+1 full-scale terms, so the sum itself never wraps.
   localparam int ACCW = BITSIZE + $clog2(N_input + 1);

   logic signed [ACCW-1:0] acc;

   always_comb begin
      acc = ACCW'(signed'(bias));
      for (int n = 0; n < N_input; n++) begin
         acc = acc + ACCW'(signed'(BITSIZE'(fxmul(word_t'(signed'(x[n*BITSIZE +: BITSIZE])),
                                                  word_t'(signed'(wcol[n*BITSIZE +: BITSIZE])),
                                                  BITSIZE, FRAC))));
      end
      y = BITSIZE'(sat(wide_t'(acc), BITSIZE));
   end

endmodule

// File: rtl/encoder_fixed_point.sv
// Dense fixed-point layer without activation: M_output parallel neurons feeding
// a single output register (1-cycle latency, a new vector every clock).
module encoder_fixed_point
   import encoder_fixed_point_pkg::*;
#(
   parameter int N_input  = 9,
   parameter int M_output = 4,
   parameter int BITSIZE  = BITSIZE_DEF,
   parameter int FRAC     = FRAC_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_input*BITSIZE-1:0]          x,
   input  logic [N_input*M_output*BITSIZE-1:0] w,
   input  logic [M_output*BITSIZE-1:0]         b,
   output logic [M_output*BITSIZE-1:0]         y
);

   logic [M_output*BITSIZE-1:0] ycomb;

   // Weights are neuron-major, so neuron m's column is one contiguous slice.
   for (genvar m = 0; m < M_output; m++) begin : g_neuron
      encoder_neuron #(
         .N_input (N_input),
         .BITSIZE (BITSIZE),
         .FRAC    (FRAC)
      ) u_neuron (
         .x    (x),
         .wcol (w[m*N_input*BITSIZE +: N_input*BITSIZE]),
         .bias (b[m*BITSIZE +: BITSIZE]),
         .y    (ycomb[m*BITSIZE +: BITSIZE])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         y <= '0;
      else
         y <= ycomb;
   end

endmodule

// File: tb/tb_encoder_fixed_point.sv
// Directed bench for encoder_fixed_point: vector table plus reset and
// back-to-back sequences, all expectations hand-computed.
module tb_encoder_fixed_point;

   localparam int N  = 9;
   localparam int M  = 4;
   localparam int BS = 32;

   localparam logic [31:0] ONE   = 32'h0001_0000;
   localparam logic [31:0] HALF  = 32'h0000_8000;
   localparam logic [31:0] NEG1  = 32'hFFFF_0000;
   localparam logic [31:0] NHALF = 32'hFFFF_8000;

   typedef struct {
      string              name;
      logic [N*BS-1:0]    x;
      logic [N*M*BS-1:0]  w;
      logic [M*BS-1:0]    b;
      logic [M*BS-1:0]    y;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N*BS-1:0]   x   = '0;
   logic [N*M*BS-1:0] w   = '0;
   logic [M*BS-1:0]   b   = '0;
   logic [M*BS-1:0]   y;

   int checks = 0;
   int errors = 0;

   vec_t tv[$];

   always #5 clk = ~clk;

   encoder_fixed_point #(
      .N_input  (N),
      .M_output (M),
      .BITSIZE  (BS),
      .FRAC     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .w   (w),
      .b   (b),
      .y   (y)
   );

   function automatic vec_t blank(input string name);
      vec_t v;
      v.name = name;
      v.x = '0;
      v.w = '0;
      v.b = '0;
      v.y = '0;
      return v;
   endfunction

   function automatic vec_t nominal();
      vec_t v;
      logic [31:0] xs[9] = '{NEG1, HALF, ONE, NEG1, HALF, ONE, NEG1, HALF, ONE};
      logic [31:0] ws[9] = '{HALF, NHALF, ONE, NEG1, HALF, ONE, NEG1, HALF, ONE};
      v = blank("nominal");
      for (int n = 0; n < N; n++) begin
         v.x[n*BS +: BS] = xs[n];
         for (int m = 0; m < M; m++)
            v.w[(m*N+n)*BS +: BS] = ws[n];
      end
      v.w[(3*N+7)*BS +: BS] = NEG1;
      v.b = {NEG1, ONE, HALF, ONE};
      v.y = {32'h0003_0000, 32'h0005_C000, 32'h0005_4000, 32'h0005_C000};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [M*BS-1:0] exp);
      for (int m = 0; m < M; m++)
         chk($sformatf("%s y[%0d]", name, m), y[m*BS +: BS], exp[m*BS +: BS]);
   endtask

   task automatic drive(input vec_t v);
      x = v.x;
      w = v.w;
      b = v.b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      vec_t nom;
      nom = nominal();

      // Table of directed vectors.
      tv.push_back(nom);

      v = blank("pos_sat");
      v.x = {N{32'h7FFF_0000}};
      v.w = {N*M{32'h7FFF_0000}};
      v.y = {M{32'h7FFF_FFFF}};
      tv.push_back(v);

      v = blank("neg_sat");
      v.x = {N{32'h7FFF_0000}};
      v.w = {N*M{32'h8000_0000}};
      v.b = {M{32'h8000_0000}};
      v.y = {M{32'h8000_0000}};
      tv.push_back(v);

      v = blank("trunc_pos");
      v.x[31:0] = 32'h0000_0001;
      for (int m = 0; m < M; m++) v.w[(m*N)*BS +: BS] = HALF;
      tv.push_back(v);

      v = blank("trunc_neg");
      v.x[31:0] = 32'hFFFF_FFFF;
      for (int m = 0; m < M; m++) v.w[(m*N)*BS +: BS] = HALF;
      v.y = {M{32'hFFFF_FFFF}};
      tv.push_back(v);

      v = blank("bias_lanes");
      v.b = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
      v.y = v.b;
      tv.push_back(v);

      v = blank("last_input");
      v.x[8*BS +: BS] = ONE;
      for (int m = 0; m < M; m++) begin
         v.w[(m*N+8)*BS +: BS] = 32'((m + 1) << 16);
         v.y[m*BS +: BS]       = 32'((m + 1) << 16);
      end
      tv.push_back(v);

      // Reset from time zero: y cleared asynchronously and held across edges.
      drive(nom);
      #1 rst = 1'b1;
      #1 chk_all("reset_async", '0);
      tick();
      chk_all("reset_hold", '0);

      @(negedge clk);
      rst = 1'b0;

      foreach (tv[i]) begin
         drive(tv[i]);
         tick();
         chk_all(tv[i].name, tv[i].y);
      end

      // Reset mid-operation between edges, held over three edges, then release.
      drive(nom);
      tick();
      chk_all("pre_reset", nom.y);
      @(negedge clk);
      rst = 1'b1;
      #1 chk_all("mid_reset", '0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("reset_edge%0d", k), '0);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_all("post_reset", nom.y);

      // Back-to-back vectors: each appears exactly one edge after it is applied.
      v = blank("zero_b1");
      v.b = {M{ONE}};
      v.y = {M{ONE}};
      drive(nom);
      tick();
      chk_all("pipe0", nom.y);
      drive(v);
      @(negedge clk);
      chk_all("pipe_hold", nom.y);
      tick();
      chk_all("pipe1", v.y);
      drive(nom);
      tick();
      chk_all("pipe2", nom.y);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
